wb_regfile_stage: RTL and testbench
===================================

Name: wb_regfile_stage

Overview:
Writeback stage directly downstream of the memory stage.
- Consumes the memory-stage latch outputs: the 2-bit op, the 16-bit data (load result or ALU address/result) and the 3-bit destination register.
- Commits that data into an 8 x 16 architectural register file.
- Serves two combinational read ports to decode, with write-through bypass.
- Drives a forwarding bus to execute and keeps a retired-instruction counter.

Parameters:
- DATA_W, 16, datapath and register width
- REG_AW, 3, register address width (2**REG_AW registers)
- CNT_W, 16, width of the retire counter

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge
- RESET  in  1  synchronous, active-high reset
- OP_IN  in  2  op from the memory-stage latch: 00 NOP, 01 ALU, 10 LOAD, 11 STORE
- DATA_IN  in  DATA_W  memory-stage latched data (load data for LOAD, result for ALU)
- DESTREG_IN  in  REG_AW  destination register from the memory-stage latch
- RS_ADDR  in  REG_AW  decode read port A address
- RT_ADDR  in  REG_AW  decode read port B address
- RS_DATA  out  DATA_W  read port A data (combinational)
- RT_DATA  out  DATA_W  read port B data (combinational)
- FWD_VALID  out  1  writeback this cycle targets a nonzero register
- FWD_REG  out  REG_AW  register being written this cycle
- FWD_DATA  out  DATA_W  value being written this cycle
- RETIRE_COUNT  out  CNT_W  count of retired non-NOP ops

Behaviour:
- Write enable: WE = (OP_IN==01 or OP_IN==10) and DESTREG_IN != 0.
  - STORE and NOP never write.
  - R0 reads 0 at all times; writes to R0 are dropped.
- Commit: on a CLOCK_50 rising edge with WE=1 and RESET=0, regs[DESTREG_IN] <= DATA_IN. One-cycle latency from input to architectural state.
- Read ports:
  - RS_DATA = 0 if RS_ADDR==0.
  - Else DATA_IN if WE and RS_ADDR==DESTREG_IN (write-through bypass).
  - Else regs[RS_ADDR].
  - RT_DATA follows the identical rule on RT_ADDR.
  - A read and a write to the same register in the same cycle returns the new value.
- Forwarding: FWD_VALID = WE, FWD_REG = DESTREG_IN, FWD_DATA = DATA_IN, all combinational. When FWD_VALID=0, FWD_REG and FWD_DATA still mirror the inputs; consumers must gate on FWD_VALID.
- Retire counter:
  - Increments by 1 on each edge where OP_IN != 00, including STORE and writes to R0.
  - Wraps from 2**CNT_W-1 to 0 with no flag.
- Reset (synchronous, sampled at the clock edge):
  - All registers R1..R7 <= 0; RETIRE_COUNT <= 0.
  - Reset has priority over a simultaneous write or count: that write is lost and the counter ends at 0.
  - During reset, read and forward outputs remain combinational functions of the inputs and the current register contents.
- Inputs with X/undefined op after power-up: treated as don't-care until the first RESET. Bench always applies RESET first.
- No stall input: one op consumed every cycle, matching the memory latch cadence.

Decomposition:
- Shared package `pipe_pkg`:
  - op encodings OP_NOP=2'b00, OP_ALU=2'b01, OP_LOAD=2'b10, OP_STORE=2'b11
  - DATA_W, REG_AW
  - helper constant ZERO_REG=0
- One natural sub-module, `regfile_2r1w`: 8 x 16 storage, synchronous write, synchronous reset clear, two async reads with bypass and R0-zero logic.
- The stage top holds the write-enable decode, forwarding outputs and retire counter.

Test Plan:
- Reset then ALU write: RESET 1 cycle; OP=01, DEST=3, DATA=16'h1234 for 1 cycle → next cycle RS_ADDR=3 gives 16'h1234; RETIRE_COUNT=1.
- Bypass: OP=10, DEST=5, DATA=16'hBEEF with RT_ADDR=5 in the same cycle → RT_DATA=16'hBEEF combinationally; FWD_VALID=1, FWD_REG=5.
- R0 and STORE no-write: OP=01, DEST=0, DATA=16'hFFFF, then OP=11, DEST=2, DATA=16'h00AA → RS_ADDR=0 reads 0; R2 reads 0; FWD_VALID=0 both cycles; RETIRE_COUNT increments by 2.
- NOP: OP=00, DEST=4, DATA=16'h5555 → R4 unchanged; RETIRE_COUNT unchanged; FWD_VALID=0.
- Reset collision: RESET=1 with OP=01, DEST=6, DATA=16'h7777 on the same edge → R6=0 and RETIRE_COUNT=0 after the edge.
- Counter wrap: force 65535 retirements (OP=11 repeatedly), then one more → RETIRE_COUNT goes 16'hFFFF → 16'h0000.

Source files
------------

// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the pipeline back end: op encodings carried by the
//   memory-stage latch, the datapath / register-address widths and the index
//   of the hard-wired zero register.
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int DATA_W   = 16;   // datapath and register width
    localparam int REG_AW   = 3;    // register address width
    localparam int ZERO_REG = 0;    // index of the register that always reads 0

    // 2-bit op encoding as it arrives from the memory-stage latch
    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_ALU   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } op_e;

endpackage : pipe_pkg

// File: rtl/regfile_2r1w.sv
// ----------------------------------------------------------------------------
// regfile_2r1w
//   2**REG_AW x DATA_W architectural register file, one synchronous write
//   port and two combinational read ports. Register 0 is hard-wired to zero.
//   A read that hits the register being written this cycle returns the new
//   value (write-through bypass).
//
// Ports
//   CLOCK_50  in   clock, write and clear on the rising edge
//   RESET     in   synchronous, active-high clear of every register
//   we        in   write enable
//   waddr     in   write address
//   wdata     in   write data
//   ra_addr   in   read port A address
//   ra_data   out  read port A data (combinational)
//   rb_addr   in   read port B address
//   rb_data   out  read port B data (combinational)
// ----------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_AW = pipe_pkg::REG_AW
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data
);

    import pipe_pkg::*;

    localparam int                NREGS = 2 ** REG_AW;
    localparam logic [REG_AW-1:0] R0    = REG_AW'(ZERO_REG);

    logic [DATA_W-1:0] regs [NREGS];

    // Writes to R0 are dropped here as well as in the decode, so the zero
    // register stays zero whatever the caller does with we.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            // NOTE: the register array is cleared on reset because the
            // architecture defines every register as zero afterwards; a
            // datapath-only array would normally be left without reset.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != R0)) begin
            // NOTE: sequential state is only ever assigned with <= so that
            // every flop samples the pre-edge values of its inputs.
            regs[waddr] <= wdata;
        end
    end

    // Read priority: zero register, then same-cycle write, then storage.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wr_en,
        input logic [REG_AW-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data
    );
        if (addr == R0) begin
            return '0;
        end else if (wr_en && (addr == wr_addr)) begin
            return wr_data;
        end else begin
            return stored;
        end
    endfunction

    assign ra_data = read_port(ra_addr, regs[ra_addr], we, waddr, wdata);
    assign rb_data = read_port(rb_addr, regs[rb_addr], we, waddr, wdata);

endmodule : regfile_2r1w

// File: rtl/wb_regfile_stage.sv
// ----------------------------------------------------------------------------
// wb_regfile_stage
//   Writeback stage fed by the memory-stage latch. Decodes whether the
//   incoming op writes a register, commits the data into the architectural
//   register file, serves two read ports to decode, publishes the write on a
//   forwarding bus for execute and counts retired (non-NOP) ops.
//
// Ports
//   CLOCK_50      in   clock, all state updates on the rising edge
//   RESET         in   synchronous, active-high reset
//   OP_IN         in   op: 00 NOP, 01 ALU, 10 LOAD, 11 STORE
//   DATA_IN       in   load data (LOAD) or result (ALU)
//   DESTREG_IN    in   destination register
//   RS_ADDR       in   decode read port A address
//   RT_ADDR       in   decode read port B address
//   RS_DATA       out  read port A data (combinational, bypassed)
//   RT_DATA       out  read port B data (combinational, bypassed)
//   FWD_VALID     out  this cycle's writeback targets a nonzero register
//   FWD_REG       out  register being written this cycle
//   FWD_DATA      out  value being written this cycle
//   RETIRE_COUNT  out  wrapping count of retired non-NOP ops
// ----------------------------------------------------------------------------
module wb_regfile_stage #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int REG_AW = pipe_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [1:0]        OP_IN,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic [REG_AW-1:0] DESTREG_IN,
    input  logic [REG_AW-1:0] RS_ADDR,
    input  logic [REG_AW-1:0] RT_ADDR,
    output logic [DATA_W-1:0] RS_DATA,
    output logic [DATA_W-1:0] RT_DATA,
    output logic              FWD_VALID,
    output logic [REG_AW-1:0] FWD_REG,
    output logic [DATA_W-1:0] FWD_DATA,
    output logic [CNT_W-1:0]  RETIRE_COUNT
);

    import pipe_pkg::*;

    op_e              op;
    logic             wr_en;
    logic             retire;
    logic [CNT_W-1:0] retire_count;

    assign op = op_e'(OP_IN);

    // Op decode. STORE retires but never writes; a write aimed at R0 still
    // retires but does not enable the register file or the forwarding bus.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        wr_en  = 1'b0;
        retire = 1'b0;
        case (op)
            OP_ALU, OP_LOAD: begin
                wr_en  = (DESTREG_IN != REG_AW'(ZERO_REG));
                retire = 1'b1;
            end
            OP_STORE: begin
                retire = 1'b1;
            end
            default: begin
                wr_en  = 1'b0;
                retire = 1'b0;
            end
        endcase
    end

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .we       (wr_en),
        .waddr    (DESTREG_IN),
        .wdata    (DATA_IN),
        .ra_addr  (RS_ADDR),
        .ra_data  (RS_DATA),
        .rb_addr  (RT_ADDR),
        .rb_data  (RT_DATA)
    );

    // Forwarding bus mirrors the inputs unconditionally; consumers qualify
    // with FWD_VALID.
    assign FWD_VALID = wr_en;
    assign FWD_REG   = DESTREG_IN;
    assign FWD_DATA  = DATA_IN;

    // Retire counter wraps silently. Reset wins over a same-edge retirement.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            retire_count <= '0;
        end else if (retire) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

    assign RETIRE_COUNT = retire_count;

endmodule : wb_regfile_stage

// File: tb/tb_wb_regfile_stage.sv
// ----------------------------------------------------------------------------
// tb_wb_regfile_stage
//   Directed and random stimulus for the writeback stage, checked against a
//   behavioural model of the architectural register file and retire count.
// ----------------------------------------------------------------------------
module tb_wb_regfile_stage;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int CW = 16;

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] ALU   = 2'b01;
    localparam logic [1:0] LOAD  = 2'b10;
    localparam logic [1:0] STORE = 2'b11;

    logic          CLOCK_50 = 1'b0;
    logic          RESET;
    logic [1:0]    OP_IN;
    logic [DW-1:0] DATA_IN;
    logic [AW-1:0] DESTREG_IN;
    logic [AW-1:0] RS_ADDR;
    logic [AW-1:0] RT_ADDR;
    logic [DW-1:0] RS_DATA;
    logic [DW-1:0] RT_DATA;
    logic          FWD_VALID;
    logic [AW-1:0] FWD_REG;
    logic [DW-1:0] FWD_DATA;
    logic [CW-1:0] RETIRE_COUNT;

    always #5 CLOCK_50 = ~CLOCK_50;

    wb_regfile_stage dut (
        .CLOCK_50     (CLOCK_50),
        .RESET        (RESET),
        .OP_IN        (OP_IN),
        .DATA_IN      (DATA_IN),
        .DESTREG_IN   (DESTREG_IN),
        .RS_ADDR      (RS_ADDR),
        .RT_ADDR      (RT_ADDR),
        .RS_DATA      (RS_DATA),
        .RT_DATA      (RT_DATA),
        .FWD_VALID    (FWD_VALID),
        .FWD_REG      (FWD_REG),
        .FWD_DATA     (FWD_DATA),
        .RETIRE_COUNT (RETIRE_COUNT)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: architectural registers and retired-op count
    int unsigned model_regs [8];
    int unsigned model_cnt;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic bit model_writes(input logic [1:0] op, input logic [AW-1:0] dest);
        return ((op == ALU) || (op == LOAD)) && (dest != 0);
    endfunction

    function automatic int unsigned model_read(input logic [AW-1:0] addr);
        if (addr == 0)
            return 0;
        if (model_writes(OP_IN, DESTREG_IN) && (addr == DESTREG_IN))
            return int'(DATA_IN);
        return model_regs[addr];
    endfunction

    // Compare every output against the model, mid low phase of the clock
    task automatic check_outputs(input string tag);
        #2;
        check({tag, ".rs"},    32'(RS_DATA),      model_read(RS_ADDR));
        check({tag, ".rt"},    32'(RT_DATA),      model_read(RT_ADDR));
        check({tag, ".fwdv"},  32'(FWD_VALID),    32'(model_writes(OP_IN, DESTREG_IN)));
        check({tag, ".fwdr"},  32'(FWD_REG),      32'(DESTREG_IN));
        check({tag, ".fwdd"},  32'(FWD_DATA),     32'(DATA_IN));
        check({tag, ".count"}, 32'(RETIRE_COUNT), model_cnt);
    endtask

    // Apply inputs at the falling edge, optionally check, then advance the
    // model across the following rising edge.
    task automatic step(input logic rst, input logic [1:0] op, input logic [AW-1:0] dest,
                        input logic [DW-1:0] data, input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt, input bit do_check, input string tag);
        @(negedge CLOCK_50);
        RESET      = rst;
        OP_IN      = op;
        DESTREG_IN = dest;
        DATA_IN    = data;
        RS_ADDR    = rs;
        RT_ADDR    = rt;
        if (do_check)
            check_outputs(tag);
        @(posedge CLOCK_50);
        if (rst) begin
            foreach (model_regs[i]) model_regs[i] = 0;
            model_cnt = 0;
        end else begin
            if (model_writes(op, dest))
                model_regs[dest] = int'(data);
            if (op != NOP)
                model_cnt = (model_cnt + 1) % 65536;
        end
    endtask

    initial begin
        RESET      = 1'b1;
        OP_IN      = NOP;
        DATA_IN    = '0;
        DESTREG_IN = '0;
        RS_ADDR    = '0;
        RT_ADDR    = '0;
        foreach (model_regs[i]) model_regs[i] = 0;
        model_cnt = 0;

        // Reset, then the reset state on a NOP cycle
        step(1'b1, NOP, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, "por");
        step(1'b0, NOP, 3'd1, 16'h0000, 3'd3, 3'd7, 1'b1, "reset_state");

        // ALU write to R3, then read back from storage
        step(1'b0, ALU, 3'd3, 16'h1234, 3'd3, 3'd0, 1'b1, "alu_wr");
        step(1'b0, NOP, 3'd0, 16'h0000, 3'd3, 3'd1, 1'b1, "alu_rd");

        // LOAD bypass onto RT in the same cycle
        step(1'b0, LOAD, 3'd5, 16'hBEEF, 3'd3, 3'd5, 1'b1, "bypass");

        // Write to R0 and STORE never write
        step(1'b0, ALU,   3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b1, "r0_wr");
        step(1'b0, STORE, 3'd2, 16'h00AA, 3'd0, 3'd2, 1'b1, "store");
        step(1'b0, NOP,   3'd4, 16'h5555, 3'd2, 3'd4, 1'b1, "nop");
        step(1'b0, NOP,   3'd0, 16'h0000, 3'd4, 3'd5, 1'b1, "after_nop");

        // Write R6 so the reset collision has something to clear
        step(1'b0, ALU, 3'd6, 16'h1111, 3'd6, 3'd3, 1'b1, "r6_pre");
        step(1'b1, ALU, 3'd6, 16'h7777, 3'd6, 3'd6, 1'b1, "rst_collide");
        step(1'b0, NOP, 3'd0, 16'h0000, 3'd6, 3'd3, 1'b1, "after_collide");

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0),
                 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)),
                 16'($urandom),
                 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)),
                 1'b1, "rand");
        end

        // Counter wrap: 65535 retirements from zero, then one more
        step(1'b1, NOP, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b1, "wrap_rst");
        for (int i = 0; i < 65535; i++) begin
            step(1'b0, STORE, 3'($urandom_range(0, 7)), 16'($urandom),
                 3'd0, 3'd0, 1'b0, "wrap_fill");
        end
        step(1'b0, STORE, 3'd1, 16'h0000, 3'd1, 3'd2, 1'b1, "wrap_ffff");
        step(1'b0, NOP,   3'd0, 16'h0000, 3'd1, 3'd2, 1'b1, "wrap_zero");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_wb_regfile_stage
